// File: rtl/baccarat_round_ctrl_pkg.sv
// Shared types and helpers for the baccarat round controller.
// Combinational helpers only; no state lives here.
// Provides the state enum, card slot codes and the third-card rule.
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DEALP1 = 4'd1,
        DEALD1 = 4'd2,
        DEALP2 = 4'd3,
        DEALD2 = 4'd4,
        EVAL   = 4'd5,
        DEALP3 = 4'd6,
        DEALD3 = 4'd7,
        WINNER = 4'd8,
        ERROR  = 4'd9
    } state_t;

    localparam logic [2:0] SLOT_NONE = 3'd0;
    localparam logic [2:0] SLOT_P1   = 3'd1;
    localparam logic [2:0] SLOT_P2   = 3'd2;
    localparam logic [2:0] SLOT_P3   = 3'd3;
    localparam logic [2:0] SLOT_D1   = 3'd4;
    localparam logic [2:0] SLOT_D2   = 3'd5;
    localparam logic [2:0] SLOT_D3   = 3'd6;

    localparam logic [3:0] NATURAL_MIN = 4'd8;

    // Face cards and tens count as zero.
    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

    // Only A..K are real cards.
    function automatic logic rank_legal(input logic [3:0] rank);
        return (rank >= 4'd1) && (rank <= 4'd13);
    endfunction

    // Banker's third-card decision given its two-card score and the player's third card value.
    function automatic logic banker_draws(input logic [3:0] dscore, input logic [3:0] v);
        logic draw;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

    // Card slot presented while in a given state; SLOT_NONE outside deal states.
    function automatic logic [2:0] slot_of(input state_t s);
        logic [2:0] slot;
        case (s)
            DEALP1:  slot = SLOT_P1;
            DEALP2:  slot = SLOT_P2;
            DEALP3:  slot = SLOT_P3;
            DEALD1:  slot = SLOT_D1;
            DEALD2:  slot = SLOT_D2;
            DEALD3:  slot = SLOT_D3;
            default: slot = SLOT_NONE;
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/baccarat_round_ctrl_if.sv
// Card handshake between the round controller and the deck/card source.
// No latency of its own; pure wiring bundle.
// Card source holds card_valid/card_rank until it sees card_req on an edge.
interface baccarat_round_ctrl_if;
    logic       card_valid;
    logic [3:0] card_rank;
    logic       card_req;
    logic [2:0] card_slot;

    modport master (
        output card_req,
        output card_slot,
        input  card_valid,
        input  card_rank
    );

    modport slave (
        input  card_req,
        input  card_slot,
        output card_valid,
        output card_rank
    );
endinterface

// File: rtl/baccarat_round_ctrl_hand_score.sv
// One hand's running score, kept modulo 10.
// Score register updates on the edge after clear/load; score_nxt is its combinational preview.
// No backpressure: load is honoured every cycle it is asserted, clear wins over load.
module baccarat_hand_score (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] value,
    output logic [3:0] score,
    output logic [3:0] score_nxt
);
    logic [4:0] sum;

    assign sum       = {1'b0, score} + {1'b0, value};
    assign score_nxt = clear ? 4'd0 :
                       load  ? ((sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0]) :
                               score;

    // Hold the hand score; synchronous active-low reset.
    always_ff @(posedge slow_clock) begin
        if (!resetb) score <= 4'd0;
        else         score <= score_nxt;
    end
endmodule

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round controller: deals six slots, applies third-card rules, lights the winner.
// Natural/stand round reaches WINNER five edges after start; each third card adds one edge.
// Waits on card_valid while card_req is high; aborts to ERROR after WAIT_LIMIT idle cycles.
// Optional tallies are built only when BACCARAT_TALLY_EN is defined.
module baccarat_round_ctrl
    import baccarat_pkg::*;
#(
    parameter int TALLY_W    = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                   slow_clock,
    input  logic                   resetb,
    input  logic                   start,
    baccarat_round_ctrl_if.master  card,
    output logic [3:0]             pscore,
    output logic [3:0]             dscore,
    output logic                   player_win_light,
    output logic                   dealer_win_light,
    output logic                   busy,
    output logic                   error,
    output logic [TALLY_W-1:0]     player_wins,
    output logic [TALLY_W-1:0]     dealer_wins,
    output logic [TALLY_W-1:0]     ties
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             deal_st;
    logic             accept;
    logic             good_card;
    logic [3:0]       card_val;
    logic             restart;
    logic             p_load;
    logic             d_load;
    logic [3:0]       p_nxt;
    logic [3:0]       d_nxt;
    logic             natural;
    logic             eval_stand;
    logic             enter_win;
    logic             wait_hit;

    assign card.card_slot = slot_of(state);
    assign deal_st        = (card.card_slot != SLOT_NONE);
    assign card.card_req  = deal_st;
    assign busy           = !(state inside {IDLE, WINNER, ERROR});

    assign accept    = deal_st && card.card_valid;
    assign good_card = accept && rank_legal(card.card_rank);
    assign card_val  = rank_to_value(card.card_rank);
    assign restart   = start && (state inside {IDLE, WINNER, ERROR});
    assign p_load    = good_card && (state inside {DEALP1, DEALP2, DEALP3});
    assign d_load    = good_card && (state inside {DEALD1, DEALD2, DEALD3});
    assign wait_hit  = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

    // Two-card evaluation: a natural, or both hands at 6 or more, ends the round.
    assign natural    = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);
    assign eval_stand = natural || ((pscore >= 4'd6) && (dscore >= 4'd6));

    // Asserted on exactly the edge that moves the FSM into WINNER.
    assign enter_win = ((state == EVAL) && eval_stand) ||
                       (good_card && (state == DEALD3)) ||
                       (good_card && (state == DEALP3) && !banker_draws(dscore, card_val));

    baccarat_hand_score u_player (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (restart),
        .load       (p_load),
        .value      (card_val),
        .score      (pscore),
        .score_nxt  (p_nxt)
    );

    baccarat_hand_score u_dealer (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (restart),
        .load       (d_load),
        .value      (card_val),
        .score      (dscore),
        .score_nxt  (d_nxt)
    );

    // Round sequencing, wait timeout, error flag and win lights.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            error            <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            // Lights use the post-edge scores so a deciding third card counts.
            if (enter_win) begin
                player_win_light <= (p_nxt >= d_nxt);
                dealer_win_light <= (d_nxt >= p_nxt);
            end
            case (state)
                IDLE: begin
                    if (start) state <= DEALP1;
                end
                WINNER, ERROR: begin
                    if (start) begin
                        state            <= DEALP1;
                        error            <= 1'b0;
                        player_win_light <= 1'b0;
                        dealer_win_light <= 1'b0;
                    end
                end
                EVAL: begin
                    if (eval_stand)           state <= WINNER;
                    else if (pscore <= 4'd5)  state <= DEALP3;
                    else                      state <= DEALD3;
                end
                default: begin
                    if (accept) begin
                        wait_cnt <= '0;
                        if (!good_card) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            case (state)
                                DEALP1:  state <= DEALD1;
                                DEALD1:  state <= DEALP2;
                                DEALP2:  state <= DEALD2;
                                DEALD2:  state <= EVAL;
                                DEALP3:  state <= banker_draws(dscore, card_val) ? DEALD3 : WINNER;
                                default: state <= WINNER;
                            endcase
                        end
                    end else if (wait_hit) begin
                        wait_cnt <= '0;
                        state    <= ERROR;
                        error    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef BACCARAT_TALLY_EN
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    logic [TALLY_W-1:0] pw_q;
    logic [TALLY_W-1:0] dw_q;
    logic [TALLY_W-1:0] tie_q;

    // Saturating outcome tallies, bumped once per round on entry to WINNER.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            pw_q  <= '0;
            dw_q  <= '0;
            tie_q <= '0;
        end else if (enter_win) begin
            if (p_nxt > d_nxt) begin
                if (pw_q != TALLY_MAX) pw_q <= pw_q + TALLY_W'(1);
            end else if (p_nxt == d_nxt) begin
                if (tie_q != TALLY_MAX) tie_q <= tie_q + TALLY_W'(1);
            end else begin
                if (dw_q != TALLY_MAX) dw_q <= dw_q + TALLY_W'(1);
            end
        end
    end

    assign player_wins = pw_q;
    assign dealer_wins = dw_q;
    assign ties        = tie_q;
`else
    assign player_wins = '0;
    assign dealer_wins = '0;
    assign ties        = '0;
`endif

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Directed bench for baccarat_round_ctrl: hand-computed rounds, timeout, illegal card, reset, saturation.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Tally expectations follow BACCARAT_TALLY_EN (zero when the feature is compiled out).
module tb_baccarat_round_ctrl;
    localparam int TALLY_W    = 8;
    localparam int WAIT_LIMIT = 15;
`ifdef BACCARAT_TALLY_EN
    localparam bit TALLY_ON = 1'b1;
`else
    localparam bit TALLY_ON = 1'b0;
`endif

    logic               slow_clock = 1'b0;
    logic               resetb     = 1'b0;
    logic               start      = 1'b0;
    logic [3:0]         pscore, dscore;
    logic               player_win_light, dealer_win_light, busy, error;
    logic [TALLY_W-1:0] player_wins, dealer_wins, ties;

    int checks = 0;
    int errors = 0;
    int exp_pw = 0;
    int exp_dw = 0;
    int exp_t  = 0;

    baccarat_round_ctrl_if cif ();

    baccarat_round_ctrl #(.TALLY_W(TALLY_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .start            (start),
        .card             (cif),
        .pscore           (pscore),
        .dscore           (dscore),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .busy             (busy),
        .error            (error),
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins),
        .ties             (ties)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tally_exp(input int n);
        int max_v;
        max_v = (1 << TALLY_W) - 1;
        if (!TALLY_ON) return 0;
        return (n > max_v) ? max_v : n;
    endfunction

    task automatic chk_tallies(input string tag);
        chk({tag, "_pw"},  32'(player_wins), 32'(tally_exp(exp_pw)));
        chk({tag, "_dw"},  32'(dealer_wins), 32'(tally_exp(exp_dw)));
        chk({tag, "_tie"}, 32'(ties),        32'(tally_exp(exp_t)));
    endtask

    task automatic chk_win(input string tag, input int p, input int d, input bit pl, input bit dl);
        chk({tag, "_pscore"}, 32'(pscore), 32'(p));
        chk({tag, "_dscore"}, 32'(dscore), 32'(d));
        chk({tag, "_plight"}, 32'(player_win_light), 32'(pl));
        chk({tag, "_dlight"}, 32'(dealer_win_light), 32'(dl));
        chk({tag, "_busy"},   32'(busy), 32'd0);
    endtask

    // Edge 0: start sampled, card_valid held high from here on.
    task automatic begin_round();
        start          = 1'b1;
        cif.card_valid = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic deal(input int rank);
        cif.card_rank = 4'(rank);
        tick();
    endtask

    initial begin
        cif.card_valid = 1'b0;
        cif.card_rank  = 4'd0;

        // Reset state
        tick();
        tick();
        chk("rst_req",   32'(cif.card_req), 32'd0);
        chk("rst_slot",  32'(cif.card_slot), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk_win("rst", 0, 0, 1'b0, 1'b0);
        chk_tallies("rst");
        resetb = 1'b1;
        tick();
        chk("idle_req", 32'(cif.card_req), 32'd0);

        // Round 1: naturals 8 vs 8 -> tie on edge 5; start while busy is ignored
        begin_round();
        chk("r1_slot_p1", 32'(cif.card_slot), 32'd1);
        chk("r1_req",     32'(cif.card_req), 32'd1);
        deal(4);
        chk("r1_slot_d1", 32'(cif.card_slot), 32'd4);
        start = 1'b1;
        deal(9);
        start = 1'b0;
        chk("r1_slot_p2_start_ignored", 32'(cif.card_slot), 32'd2);
        deal(4);
        deal(9);
        chk("r1_eval_busy", 32'(busy), 32'd1);
        chk("r1_eval_req",  32'(cif.card_req), 32'd0);
        tick();
        chk_win("r1", 8, 8, 1'b1, 1'b1);
        exp_t++;
        chk_tallies("r1");

        // Round 2: player draws 5, banker stands on 7 -> player 8 vs 7 on edge 6
        begin_round();
        deal(2); deal(7); deal(1); deal(13);
        tick();
        chk("r2_slot_p3", 32'(cif.card_slot), 32'd3);
        deal(5);
        chk_win("r2", 8, 7, 1'b1, 1'b0);
        exp_pw++;

        // Round 3: banker on 3 stands on a player third card of 8 -> 1 vs 3
        begin_round();
        deal(1); deal(2); deal(2); deal(1);
        tick();
        deal(8);
        chk_win("r3", 1, 3, 1'b0, 1'b1);
        exp_dw++;

        // Round 4: player third 7 -> banker draws 6 -> 0 vs 9 on edge 7
        begin_round();
        deal(1); deal(2); deal(2); deal(1);
        tick();
        deal(7);
        chk("r4_slot_d3", 32'(cif.card_slot), 32'd6);
        chk("r4_pscore",  32'(pscore), 32'd0);
        chk("r4_busy",    32'(busy), 32'd1);
        deal(6);
        chk_win("r4", 0, 9, 1'b0, 1'b1);
        exp_dw++;

        // Round 5: player stands on 6, banker on 3 draws a king -> 6 vs 3 on edge 6
        begin_round();
        deal(3); deal(2); deal(3); deal(1);
        tick();
        chk("r5_slot_d3", 32'(cif.card_slot), 32'd6);
        chk("r5_pscore",  32'(pscore), 32'd6);
        deal(13);
        chk_win("r5", 6, 3, 1'b1, 1'b0);
        exp_pw++;
        chk_tallies("r5");

        // Timeout in DEALD1
        begin_round();
        deal(5);
        cif.card_valid = 1'b0;
        repeat (WAIT_LIMIT - 1) tick();
        chk("to_still_waiting", 32'(cif.card_slot), 32'd4);
        chk("to_no_err_yet",    32'(error), 32'd0);
        tick();
        chk("to_error",   32'(error), 32'd1);
        chk("to_req",     32'(cif.card_req), 32'd0);
        chk("to_busy",    32'(busy), 32'd0);
        chk("to_plight",  32'(player_win_light), 32'd0);
        chk("to_pscore",  32'(pscore), 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_restart_err",   32'(error), 32'd0);
        chk("to_restart_slot",  32'(cif.card_slot), 32'd1);
        chk("to_restart_score", 32'(pscore), 32'd0);

        // Illegal rank 14 in DEALD1 -> ERROR, card not scored
        cif.card_valid = 1'b1;
        deal(3);
        chk("ill_pscore_pre", 32'(pscore), 32'd3);
        deal(14);
        chk("ill_error",  32'(error), 32'd1);
        chk("ill_dscore", 32'(dscore), 32'd0);
        chk("ill_pscore", 32'(pscore), 32'd3);
        chk("ill_req",    32'(cif.card_req), 32'd0);
        chk_tallies("ill");

        // Reset during DEALP3 with a card presented
        begin_round();
        deal(1); deal(2); deal(2); deal(1);
        tick();
        chk("mr_slot_p3", 32'(cif.card_slot), 32'd3);
        cif.card_rank = 4'd5;
        resetb = 1'b0;
        tick();
        chk("mr_req",   32'(cif.card_req), 32'd0);
        chk("mr_slot",  32'(cif.card_slot), 32'd0);
        chk("mr_error", 32'(error), 32'd0);
        chk_win("mr", 0, 0, 1'b0, 1'b0);
        exp_pw = 0;
        exp_dw = 0;
        exp_t  = 0;
        chk_tallies("mr");
        resetb = 1'b1;
        tick();

        // Player-win saturation: 2^TALLY_W + 1 rounds
        for (int i = 0; i < (1 << TALLY_W) + 1; i++) begin
            begin_round();
            deal(2); deal(7); deal(1); deal(13);
            tick();
            deal(5);
            exp_pw++;
        end
        chk_win("sat", 8, 7, 1'b1, 1'b0);
        chk_tallies("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
